// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the execute-stage ALU. Holds the 4-bit ALU
//            control codes (the same set the ALU-control decoder emits) and
//            the two-state execute FSM encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1001;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ex_state_e;

  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_comb
// Purpose  : Purely combinational single-cycle ALU datapath plus a one-bit
//            shift step used by the serial shifter in the execute stage.
// Ports    : alu_ctrl  in  4      ALU control code
//            op_a      in  WIDTH  first operand
//            op_b      in  WIDTH  second operand
//            sh_in     in  WIDTH  value to be shifted by one bit
//            sh_left   in  1      1 = shift left, 0 = logical shift right
//            alu_out   out WIDTH  single-cycle result
//            sh_out    out WIDTH  sh_in shifted by one position
// Revision : 1.0 - initial release
// ============================================================================
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sh_in,
  input  logic             sh_left,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] sh_out
);

  logic w_lt;

  assign w_lt = $signed(op_a) < $signed(op_b);

  always_comb begin
    alu_out = '0;
    case (alu_ctrl)
      ALU_ADD: alu_out = op_a + op_b;
      ALU_SUB: alu_out = op_a - op_b;
      ALU_AND: alu_out = op_a & op_b;
      ALU_OR:  alu_out = op_a | op_b;
      ALU_NOR: alu_out = ~(op_a | op_b);
      ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, w_lt};
      // A shift reaching this path has a zero shift amount: pass op_b.
      ALU_SLL: alu_out = op_b;
      ALU_SRL: alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  assign sh_out = sh_left ? {sh_in[WIDTH-2:0], 1'b0} : {1'b0, sh_in[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/ex_alu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_stage
// Purpose  : Execute-stage ALU with internal EX/MEM output register. Logical,
//            arithmetic and slt ops complete in one cycle; shifts with a
//            non-zero amount run one bit per cycle while stall is raised.
// Ports    : clk            in  1        rising-edge clock
//            rst            in  1        synchronous active-high reset
//            valid_in       in  1        ID/EX holds a live instruction
//            alu_ctrl       in  4        ALU control code
//            op_a           in  WIDTH    rs operand
//            op_b           in  WIDTH    rt/immediate, shift source
//            shamt          in  SHAMT_W  shift amount
//            rd_in          in  5        destination register
//            reg_write_in   in  1        write-back enable
//            flush          in  1        squash the presented instruction
//            result         out WIDTH    EX/MEM result
//            zero           out 1        result == 0
//            rd_out         out 5        EX/MEM destination register
//            reg_write_out  out 1        EX/MEM write-back enable
//            valid_out      out 1        EX/MEM holds a live instruction
//            stall          out 1        freeze PC, IF/ID and ID/EX
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [4:0]         rd_in,
  input  logic               reg_write_in,
  input  logic               flush,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic [4:0]         rd_out,
  output logic               reg_write_out,
  output logic               valid_out,
  output logic               stall
);

  ex_state_e          r_state;
  logic [WIDTH-1:0]   r_sh;
  logic [SHAMT_W-1:0] r_cnt;
  logic [4:0]         r_hold_rd;
  logic               r_hold_rw;
  logic               r_hold_left;

  logic               w_accept;
  logic               w_serial;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_sh_next;

  assign w_accept = (r_state == ST_IDLE) && valid_in && !flush;
  assign w_serial = is_shift_op(alu_ctrl) && (shamt != '0);
  assign stall    = (r_state == ST_SHIFT);

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .sh_in    (r_sh),
    .sh_left  (r_hold_left),
    .alu_out  (w_alu),
    .sh_out   (w_sh_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sh          <= '0;
      r_cnt         <= '0;
      r_hold_rd     <= '0;
      r_hold_rw     <= 1'b0;
      r_hold_left   <= 1'b0;
      result        <= '0;
      zero          <= 1'b0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      valid_out     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_serial) begin
            // Park the instruction; the EX/MEM slot becomes a bubble while
            // the serial shifter works.
            r_sh          <= op_b;
            r_cnt         <= shamt;
            r_hold_rd     <= rd_in;
            r_hold_rw     <= reg_write_in;
            r_hold_left   <= (alu_ctrl == ALU_SLL);
            r_state       <= ST_SHIFT;
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
          end else if (w_accept) begin
            result        <= w_alu;
            zero          <= (w_alu == '0);
            rd_out        <= rd_in;
            reg_write_out <= reg_write_in;
            valid_out     <= 1'b1;
          end else begin
            // Bubble: data fields hold, only the qualifiers drop.
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            // Last step: retire straight from the shifter output.
            result        <= w_sh_next;
            zero          <= (w_sh_next == '0);
            rd_out        <= r_hold_rd;
            reg_write_out <= r_hold_rw;
            valid_out     <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
